data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Multi-cycle data-memory responder on the memory side of the CPU's MEM-stage port
//  (addr/MemRead/MemWrite/write data in, read data out).
//  Adds a fixed, configurable access latency and a stall_o handshake. The pipeline
//  freezes while an access is outstanding and advances on the ack cycle.
//  Replaces the single-cycle data memory once pipeline stall support is in place.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words of backing storage (power of two)
//  LATENCY  4     BUSY cycles per access, >=1; BUSY-cycle count from one accepted
//                 request to the cycle the access is performed
// PORTS
//  clk_i       in   1   clock, rising edge
//  rst_i       in   1   asynchronous reset, active-high
//  addr_i      in   32  byte address; word index = addr_i[log2(DEPTH)+1:2]
//  MemRead_i   in   1   read request, level, held by CPU while stall_o=1
//  MemWrite_i  in   1   write request, level, held by CPU while stall_o=1
//  data_i      in   32  write data
//  data_o      out  32  read data, valid in the ack_o cycle and held until next read completes
//  stall_o     out  1   1 = access outstanding, CPU must freeze PC/IFID/IDEX/EXMEM/MEMWB
//  ack_o       out  1   one-cycle pulse, access complete
// BEHAVIOUR
//  - Reset (async, rst_i=1): state=IDLE, cnt=0, data_o=0, ack_o=0, latched addr/data/op=0.
//    Memory array is not cleared.
//  - stall_o is combinational: 1 in BUSY, and 1 in IDLE when MemRead_i|MemWrite_i=1.
//    It is 0 in DONE and in idle IDLE.
//  - FSM states and transitions:
//    IDLE: on request, latch word addr, data_i and op, load cnt=LATENCY-1, go BUSY.
//          With no request, stay in IDLE.
//    BUSY: if cnt==0, perform the access at this edge and go DONE.
//          A write stores data_i into mem[idx]; a read loads mem[idx] into data_o.
//          Otherwise cnt<=cnt-1 and stay in BUSY.
//    DONE: ack_o=1, stall_o=0, always returns to IDLE.
//          A request present during DONE is ignored. The CPU advances at this edge, so
//          the next request appears in the following IDLE cycle.
//  - Timing: request first seen in cycle t.
//    * stall_o=1 in cycles t..t+LATENCY.
//    * ack_o=1 in cycle t+LATENCY+1.
//    * Back-to-back issue period is LATENCY+2 cycles.
//  - Inputs are sampled only in IDLE. Changes on addr_i/data_i during BUSY have no effect.
//  - MemRead_i and MemWrite_i both 1: treated as a write. data_o is unchanged.
//  - addr_i[1:0] are ignored (word access only).
//  - Address bits above the index are ignored, so the address wraps modulo DEPTH words.
//  - A write updates the array only. data_o keeps the last read value.
//  - A read of a word written by the immediately preceding access returns the new value.
//  - Reset mid-access: the pending access is aborted and a pending write is NOT performed.
//    FSM returns to IDLE and stall_o drops unless a request is still asserted.
//  - cnt width = clog2(LATENCY)+1. It never underflows.
// TESTING
//  1. LATENCY=4, write addr 0x10 data 0xDEADBEEF at cycle 0
//     -> stall_o=1 in cycles 0-4, ack_o=1 in cycle 5, mem[4]=0xDEADBEEF.
//  2. Read addr 0x10 after test 1
//     -> data_o=0xDEADBEEF in the ack cycle and held over 3 idle cycles.
//  3. Read and write both 1: addr 0x20 data 0x1234, then read 0x20
//     -> write performed, first ack leaves data_o unchanged, second returns 0x00001234.
//  4. Aliasing/wrap, DEPTH=1024: write 0xA5 to addr 0x1000+0x8, read addr 0x8
//     -> returns 0xA5. Read addr 0x9 -> also 0xA5.
//  5. Assert rst_i in cycle 2 of a write of 0x55 to addr 0x40
//     -> outputs reset, mem[16] unchanged, stall_o=0 once the request is deasserted.
//  6. LATENCY=1, back-to-back reads at 0x0 and 0x4
//     -> ack pulses in cycles 2 and 5, stall_o low only in cycles 2 and 5.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage port: fixed access latency,
// stall handshake towards the pipeline, and a one-cycle ack when the access completes.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic          op_write;
    logic          req;
    logic          perform;
    logic [31:0]   mem [DEPTH];

    // Byte-offset bits and bits above the word index are deliberately dropped,
    // so addresses alias modulo DEPTH words.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign req     = MemRead_i | MemWrite_i;
    assign perform = (state == BUSY) && (cnt == '0);
    assign stall_o = (state == BUSY) || ((state == IDLE) && req);
    assign ack_o   = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            wdata    <= '0;
            op_write <= 1'b0;
            data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        idx      <= addr_i[AW+1:2];
                        wdata    <= data_i;
                        op_write <= MemWrite_i;
                        cnt      <= CW'(LATENCY - 1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (!op_write) begin
                            data_o <= mem[idx];
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; clearing it would cost a DEPTH-wide
    // reset fan-out and prevent mapping onto RAM. A write aborted by reset never
    // fires because the enable is qualified by the live FSM state and rst_i.
    always_ff @(posedge clk_i) begin
        if (perform && op_write && !rst_i) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=4 for data-path
// tests and one at LATENCY=1 for back-to-back timing.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst4, rst1;
    logic [31:0] addr4, data_in4, addr1, data_in1;
    logic        rd4, wr4, rd1, wr1;
    logic [31:0] data_out4, data_out1;
    logic        stall4, ack4, stall1, ack1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .LATENCY(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst4), .addr_i(addr4), .MemRead_i(rd4), .MemWrite_i(wr4),
        .data_i(data_in4), .data_o(data_out4), .stall_o(stall4), .ack_o(ack4)
    );

    data_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .addr_i(addr1), .MemRead_i(rd1), .MemWrite_i(wr1),
        .data_i(data_in1), .data_o(data_out1), .stall_o(stall1), .ack_o(ack1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Caller is #1 after a rising edge with the LATENCY=4 DUT idle. Request is seen
    // in cycle 0, stall expected in cycles 0..4, ack in cycle 5; returns #1 into
    // the following IDLE cycle with the request removed.
    task automatic access4(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdat, input logic [31:0] exp_data,
                           input string tag);
        rd4 = rd; wr4 = wr; addr4 = addr; data_in4 = wdat;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check({tag, " stall busy"}, 32'(stall4), 32'd1);
            check({tag, " ack busy"}, 32'(ack4), 32'd0);
            @(posedge clk); #1;
            // Input changes while busy must not matter.
            addr4 = 32'h0000_03FC; data_in4 = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        check({tag, " stall done"}, 32'(stall4), 32'd0);
        check({tag, " ack done"}, 32'(ack4), 32'd1);
        check({tag, " data_o"}, data_out4, exp_data);
        @(posedge clk); #1;
        rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; data_in4 = '0;
    endtask

    logic exp_stall1 [6];
    logic exp_ack1   [6];

    initial begin
        rst4 = 1'b1; rst1 = 1'b1;
        rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; data_in4 = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; data_in1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset stall4", 32'(stall4), 32'd0);
        check("reset ack4", 32'(ack4), 32'd0);
        check("reset data4", data_out4, 32'd0);
        check("reset stall1", 32'(stall1), 32'd0);
        check("reset ack1", 32'(ack1), 32'd0);
        rst4 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        // 1/2: write then read back, data held over idle cycles
        access4(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, "t1 write");
        access4(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, "t2 read");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2 hold data", data_out4, 32'hDEAD_BEEF);
            check("t2 idle stall", 32'(stall4), 32'd0);
            @(posedge clk); #1;
        end

        // 3: read+write together acts as a write, data_o untouched
        access4(1'b1, 1'b1, 32'h20, 32'h0000_1234, 32'hDEAD_BEEF, "t3 rdwr");
        access4(1'b1, 1'b0, 32'h20, 32'h0, 32'h0000_1234, "t3 read");

        // 4: aliasing above the index and ignored byte offset
        access4(1'b0, 1'b1, 32'h1008, 32'h0000_00A5, 32'h0000_1234, "t4 write");
        access4(1'b1, 1'b0, 32'h8, 32'h0, 32'h0000_00A5, "t4 read 8");
        access4(1'b1, 1'b0, 32'h9, 32'h0, 32'h0000_00A5, "t4 read 9");

        // 5: reset during a write aborts it; prior contents survive
        access4(1'b0, 1'b1, 32'h40, 32'h0000_0011, 32'h0000_00A5, "t5 prewrite");
        rd4 = 1'b0; wr4 = 1'b1; addr4 = 32'h40; data_in4 = 32'h0000_0055;
        repeat (2) @(posedge clk);
        #1;
        rst4 = 1'b1;
        @(negedge clk);
        check("t5 rst data", data_out4, 32'd0);
        check("t5 rst ack", 32'(ack4), 32'd0);
        check("t5 rst stall req held", 32'(stall4), 32'd1);
        wr4 = 1'b0;
        #1;
        check("t5 rst stall released", 32'(stall4), 32'd0);
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(posedge clk); #1;
        access4(1'b1, 1'b0, 32'h40, 32'h0, 32'h0000_0011, "t5 readback");

        // 6: LATENCY=1 back-to-back reads, period 3
        exp_stall1 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_ack1   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        rd1 = 1'b1; addr1 = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("t6 stall c%0d", c), 32'(stall1), 32'(exp_stall1[c]));
            check($sformatf("t6 ack c%0d", c), 32'(ack1), 32'(exp_ack1[c]));
            @(posedge clk); #1;
            if (c == 2) addr1 = 32'h4;
        end
        rd1 = 1'b0;
        @(negedge clk);
        check("t6 final stall", 32'(stall1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
